// File: rtl/can_register_pkg.sv
// Shared types and helpers for the CAN control/status register bank.
// Mode encoding per register plus a slicer for packed per-register parameters.
package can_register_pkg;

   typedef enum logic [1:0] {
      REG_RW  = 2'd0,
      REG_RO  = 2'd1,
      REG_W1C = 2'd2,
      REG_RC  = 2'd3
   } reg_mode_e;

   localparam int MAX_PACK = 1024;

   // Returns field idx (width bits) of a packed parameter, zero-extended to 64 bits.
   function automatic logic [63:0] reg_field(input logic [MAX_PACK-1:0] packed_val,
                                             input int idx, input int width);
      logic [MAX_PACK-1:0] sh;
      sh = packed_val >> (idx * width);
      return sh[63:0] & ((64'd1 << width) - 64'd1);
   endfunction

endpackage

// File: rtl/can_register_cell.sv
// One WIDTH-bit register with a fixed access mode (RW/RO/W1C/RC); optional parity under CAN_REG_PARITY_EN.
// Latency: updates visible one cycle after wr/rd_clr/hw_set. No backpressure: every strobe is taken.
module can_register_cell
   import can_register_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter reg_mode_e        MODE      = REG_RW,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_clr,
   input  logic [WIDTH-1:0] hw_set,
   input  logic [WIDTH-1:0] hw_val,
`ifdef CAN_REG_PARITY_EN
   input  logic             parity_inject,
   output logic             par_ok,
`endif
   output logic [WIDTH-1:0] stored,
   output logic [WIDTH-1:0] rd_val,
   output logic             sticky
);

   // Not every mode consumes every input.
   logic unused_ok;
   assign unused_ok = ^{wr, wdata, rd_clr, hw_set, hw_val};

   if (MODE == REG_RO) begin : g_ro
      assign stored = '0;
      assign rd_val = hw_val;
      assign sticky = 1'b0;
`ifdef CAN_REG_PARITY_EN
      logic unused_par;
      assign unused_par = parity_inject ^ clk ^ rst;
      assign par_ok     = 1'b1;
`else
      logic unused_clk;
      assign unused_clk = clk ^ rst;
`endif
   end else begin : g_store
      logic [WIDTH-1:0] val;
      logic [WIDTH-1:0] nxt;

      always_comb begin
         nxt = val;
         case (MODE)
            REG_RW:  if (wr) nxt = wdata;
            REG_W1C: nxt = (wr ? (val & ~wdata) : val) | hw_set;
            REG_RC:  nxt = rd_clr ? hw_set : (val | hw_set);
            default: nxt = val;
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst) val <= RESET_VAL;
         else     val <= nxt;
      end

      assign stored = val;
      assign rd_val = val;
      assign sticky = (MODE == REG_W1C || MODE == REG_RC) && (|val);

`ifdef CAN_REG_PARITY_EN
      logic par;
      logic inj_pend;
      logic upd;

      assign upd = (MODE == REG_RW)  ? wr :
                   (MODE == REG_W1C) ? (wr | (|hw_set)) :
                                       (rd_clr | (|hw_set));

      // An inject request waits for the next load of this register, then corrupts its parity.
      always_ff @(posedge clk) begin
         if (rst) begin
            par      <= ^RESET_VAL;
            inj_pend <= 1'b0;
         end else if (upd) begin
            par      <= (^nxt) ^ (parity_inject | inj_pend);
            inj_pend <= 1'b0;
         end else begin
            inj_pend <= inj_pend | parity_inject;
         end
      end

      assign par_ok = ((^val) == par);
`endif
   end

endmodule

// File: rtl/can_register_bank.sv
// Bank of NUM_REGS mode-configurable registers with registered read path and aggregated irq (parity: CAN_REG_PARITY_EN).
// Latency: writes visible on reg_out next cycle; rdata/rvalid one cycle after re. No backpressure.
module can_register_bank
   import can_register_pkg::*;
#(
   parameter int                        NUM_REGS    = 8,
   parameter int                        WIDTH       = 8,
   parameter int                        AW          = 3,
   parameter logic [NUM_REGS*2-1:0]     REG_MODE    = '0,
   parameter logic [NUM_REGS*WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [AW-1:0]             addr,
   input  logic                      we,
   input  logic [WIDTH-1:0]          wdata,
   input  logic                      re,
   output logic [WIDTH-1:0]          rdata,
   output logic                      rvalid,
   input  logic [NUM_REGS*WIDTH-1:0] hw_set,
   input  logic [NUM_REGS*WIDTH-1:0] hw_val,
   output logic [NUM_REGS*WIDTH-1:0] reg_out,
`ifdef CAN_REG_PARITY_EN
   input  logic                      parity_inject,
   output logic                      parity_err,
`endif
   output logic                      irq
);

   logic [WIDTH-1:0]    rd_val [NUM_REGS];
   logic [NUM_REGS-1:0] sticky;
   logic [NUM_REGS-1:0] par_ok;
   logic [WIDTH-1:0]    rd_mux;
   logic                rd_ok;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      localparam reg_mode_e MODE =
         reg_mode_e'(2'(reg_field(MAX_PACK'(REG_MODE), i, 2)));
      localparam logic [WIDTH-1:0] RV =
         WIDTH'(reg_field(MAX_PACK'(RESET_VALUE), i, WIDTH));

      logic hit;
      assign hit = (addr == AW'(i));

      can_register_cell #(
         .WIDTH     (WIDTH),
         .MODE      (MODE),
         .RESET_VAL (RV)
      ) u_cell (
         .clk           (clk),
         .rst           (rst),
         .wr            (we & hit),
         .wdata         (wdata),
         .rd_clr        (re & hit),
         .hw_set        (hw_set[i*WIDTH +: WIDTH]),
         .hw_val        (hw_val[i*WIDTH +: WIDTH]),
`ifdef CAN_REG_PARITY_EN
         .parity_inject (parity_inject),
         .par_ok        (par_ok[i]),
`endif
         .stored        (reg_out[i*WIDTH +: WIDTH]),
         .rd_val        (rd_val[i]),
         .sticky        (sticky[i])
      );
`ifndef CAN_REG_PARITY_EN
      assign par_ok[i] = 1'b1;
`endif
   end

   // Addresses past the last register fall through with zero data and no parity fault.
   always_comb begin
      rd_mux = '0;
      rd_ok  = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr == AW'(i)) begin
            rd_mux = rd_val[i];
            rd_ok  = par_ok[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= re;
         rdata  <= re ? rd_mux : '0;
      end
   end

`ifdef CAN_REG_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst)              parity_err <= 1'b0;
      else if (re && !rd_ok) parity_err <= 1'b1;
   end
`else
   logic unused_par;
   assign unused_par = rd_ok;
`endif

   assign irq = |sticky;

endmodule

// File: tb/tb_can_register_bank.sv
// Scoreboard bench for can_register_bank: six registers (RW,RW,RW,W1C,RC,RO), reg2 resets to 0xA5.
module tb_can_register_bank;

   localparam int NR = 6;
   localparam int W  = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [2:0]      addr = '0;
   logic            we = 1'b0;
   logic [W-1:0]    wdata = '0;
   logic            re = 1'b0;
   logic [W-1:0]    rdata;
   logic            rvalid;
   logic [NR*W-1:0] hw_set = '0;
   logic [NR*W-1:0] hw_val = '0;
   logic [NR*W-1:0] reg_out;
   logic            irq;
`ifdef CAN_REG_PARITY_EN
   logic            parity_inject = 1'b0;
   logic            parity_err;
`endif

   can_register_bank #(
      .NUM_REGS    (NR),
      .WIDTH       (W),
      .AW          (3),
      .REG_MODE    (12'h780),
      .RESET_VALUE (48'h0000_00A5_0000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .addr          (addr),
      .we            (we),
      .wdata         (wdata),
      .re            (re),
      .rdata         (rdata),
      .rvalid        (rvalid),
      .hw_set        (hw_set),
      .hw_val        (hw_val),
      .reg_out       (reg_out),
`ifdef CAN_REG_PARITY_EN
      .parity_inject (parity_inject),
      .parity_err    (parity_err),
`endif
      .irq           (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        tag;
      logic [W-1:0] dat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] fld(input int i);
      return reg_out[i*W +: W];
   endfunction

   task automatic rd(input logic [2:0] a, input logic [W-1:0] exp, input string tag);
      exp_t e;
      e.tag = tag;
      e.dat = exp;
      addr  = a;
      re    = 1'b1;
      sb.push_back(e);
      step();
      re = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      step();
      we = 1'b0;
   endtask

   // Read monitor: every rvalid pops one expectation; idle cycles must show rdata=0.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (rvalid) begin
               if (sb.size() == 0) begin
                  check("rd_unexpected", 64'(rvalid), 64'd0);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check(e.tag, 64'(rdata), 64'(e.dat));
               end
            end else begin
               check("rdata_idle", 64'(rdata), 64'd0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      step();
      step();
      rst = 1'b0;
      check("rst_reg_out", 64'(reg_out), 64'h0000_00A5_0000);
      check("rst_rvalid", 64'(rvalid), 64'd0);
      check("rst_irq", 64'(irq), 64'd0);
      mon_en = 1'b1;
      rd(3'd2, 8'hA5, "rst_rd2");

      // Reset during a read cancels it.
      wr(3'd2, 8'h11);
      check("rw_wr2", 64'(fld(2)), 64'h11);
      addr = 3'd2;
      re   = 1'b1;
      rst  = 1'b1;
      step();
      re  = 1'b0;
      rst = 1'b0;
      check("rst_abort_rvalid", 64'(rvalid), 64'd0);
      check("rst_reload2", 64'(fld(2)), 64'hA5);

      // RW: same-cycle write and read returns the old value.
      addr  = 3'd1;
      wdata = 8'h3C;
      we    = 1'b1;
      begin
         exp_t e;
         e.tag = "rw_rd_old";
         e.dat = 8'h00;
         sb.push_back(e);
      end
      re = 1'b1;
      step();
      we = 1'b0;
      re = 1'b0;
      check("rw_reg_out1", 64'(fld(1)), 64'h3C);
      rd(3'd1, 8'h3C, "rw_rd_new");

      // W1C
      hw_set[3*W +: W] = 8'h81;
      step();
      hw_set = '0;
      check("w1c_set", 64'(fld(3)), 64'h81);
      check("w1c_irq", 64'(irq), 64'd1);
      hw_set[3*W] = 1'b1;
      wr(3'd3, 8'h01);
      hw_set = '0;
      check("w1c_set_wins", 64'(fld(3)), 64'h81);
      wr(3'd3, 8'h01);
      check("w1c_clr_bit0", 64'(fld(3)), 64'h80);
      wr(3'd3, 8'h80);
      check("w1c_clr_all", 64'(fld(3)), 64'h00);
      check("w1c_irq_off", 64'(irq), 64'd0);

      // RC
      hw_set[4*W +: W] = 8'h10;
      step();
      hw_set = '0;
      check("rc_set", 64'(fld(4)), 64'h10);
      check("rc_irq", 64'(irq), 64'd1);
      wr(3'd4, 8'hFF);
      check("rc_wr_ignored", 64'(fld(4)), 64'h10);
      rd(3'd4, 8'h10, "rc_rd");
      check("rc_cleared", 64'(fld(4)), 64'h00);
      check("rc_irq_off", 64'(irq), 64'd0);
      hw_set[4*W +: W] = 8'h04;
      step();
      hw_set[4*W +: W] = 8'h02;
      rd(3'd4, 8'h04, "rc_rd_race");
      hw_set = '0;
      check("rc_survive", 64'(fld(4)), 64'h02);
      hw_set[4*W +: W] = 8'h08;
      step();
      hw_set = '0;
      // Back-to-back reads: the second sees only bits set since the first.
      addr = 3'd4;
      re   = 1'b1;
      begin
         exp_t e;
         e.tag = "rc_burst0";
         e.dat = 8'h0A;
         sb.push_back(e);
         step();
         hw_set[4*W +: W] = 8'h40;
         e.tag = "rc_burst1";
         e.dat = 8'h00;
         sb.push_back(e);
         step();
         hw_set = '0;
         e.tag = "rc_burst2";
         e.dat = 8'h40;
         sb.push_back(e);
         step();
      end
      re = 1'b0;
      check("rc_burst_end", 64'(fld(4)), 64'h00);

      // Out of range and RO
      rd(3'd7, 8'h00, "oor_rd7");
      rd(3'd6, 8'h00, "oor_rd6");
      wr(3'd7, 8'hFF);
      wr(3'd6, 8'hFF);
      check("oor_wr", 64'(reg_out), 64'h0000_00A5_3C00);
      hw_val[5*W +: W] = 8'h5A;
      rd(3'd5, 8'h5A, "ro_rd");
      hw_val[5*W +: W] = 8'hC3;
      wr(3'd5, 8'hFF);
      check("ro_no_store", 64'(fld(5)), 64'h00);
      rd(3'd5, 8'hC3, "ro_rd_live");
      hw_val = '0;

      // Parity
`ifdef CAN_REG_PARITY_EN
      parity_inject = 1'b1;
      wr(3'd1, 8'h01);
      parity_inject = 1'b0;
      check("par_quiet", 64'(parity_err), 64'd0);
      rd(3'd1, 8'h01, "par_rd");
      check("par_err", 64'(parity_err), 64'd1);
      step();
      step();
      check("par_err_held", 64'(parity_err), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("par_err_rst", 64'(parity_err), 64'd0);
`else
      wr(3'd1, 8'h01);
      rd(3'd1, 8'h01, "par_rd");
`endif

      step();
      step();
      check("sb_drain", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/can_register_bank.md
Name: can_register_bank

Overview:
- Parametrised bank of NUM_REGS control/status registers, each WIDTH bits wide.
- Each register has a per-register access mode: RW, RO, W1C or RC.
- Sits between the CPU interface decoder and the CAN core. It replaces individually instantiated single registers for mode, command, status and interrupt registers.
- Provides a registered read path, sticky hardware-set status bits and an aggregated interrupt output.

Parameters:
- NUM_REGS, 8, number of registers in the bank.
- WIDTH, 8, bits per register.
- AW, 3, address width; NUM_REGS <= 2**AW.
- REG_MODE, 0, packed NUM_REGS*2 bits; field i selects the mode of register i (encoding in package).
- RESET_VALUE, 0, packed NUM_REGS*WIDTH bits; field i is the reset value of register i.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high; loads every register with its RESET_VALUE field.
- addr  input  AW  register index for the read/write access.
- we  input  1  write strobe, single-cycle.
- wdata  input  WIDTH  write data.
- re  input  1  read strobe, single-cycle.
- rdata  output  WIDTH  read data, valid while rvalid=1.
- rvalid  output  1  pulses one cycle after an accepted re.
- hw_set  input  NUM_REGS*WIDTH  per-bit hardware set for W1C/RC registers.
- hw_val  input  NUM_REGS*WIDTH  live value of RO registers.
- reg_out  output  NUM_REGS*WIDTH  current contents of all stored registers (RO fields read 0).
- irq  output  1  OR of all bits of all W1C and RC registers.

Behaviour:
- Reset: while rst=1 at a clock edge, the stored value of register i becomes RESET_VALUE[i]; rdata=0, rvalid=0. rst dominates we, re and hw_set. Reset asserted mid-access aborts the access: the next cycle has rvalid=0.
- Write latency 1: a write with we=1 is visible on reg_out the next cycle.
- RW mode: value <= wdata on write; hw_set ignored.
- RO mode: writes ignored; no storage; reads return hw_val[i] sampled at the edge of re.
- W1C mode:
  - value <= (value & ~wdata) | hw_set on write; value <= value | hw_set otherwise.
  - Set wins over a simultaneous clear of the same bit.
- RC mode:
  - Writes ignored; value <= value | hw_set every cycle.
  - On an accepted read, rdata returns the pre-clear value and the register becomes hw_set (bits set in the same cycle survive).
- Read latency 1: rdata/rvalid are registered; rvalid=1 exactly one cycle per re; rdata=0 when rvalid=0.
- Out of range (addr >= NUM_REGS): write ignored; read returns 0 with rvalid=1.
- Same-cycle we and re, same address: read returns the pre-write value. The write is applied; an RC clear and a write do not interact because RC ignores writes.
- re held high for N cycles gives N reads; for RC, the second and later reads return only bits set since the previous read.
- irq is combinational from stored state; it deasserts the cycle after the last sticky bit clears.

Optional Feature:
- Macro: CAN_REG_PARITY_EN.
- Defined:
  - Each stored register carries an even-parity bit, computed on every update.
  - An extra output parity_err (1 bit) is registered; it goes high the cycle after a read whose stored data/parity mismatch, and stays set until rst.
  - Test-only input parity_inject (1 bit) inverts the parity bit written on the next update.
- Not defined: no parity storage, no parity_err or parity_inject ports; behaviour otherwise identical.

Decomposition:
- Package can_register_pkg:
  - typedef enum logic [1:0] reg_mode_e: REG_RW=0, REG_RO=1, REG_W1C=2, REG_RC=3.
  - Helper function reg_field to slice packed parameters.
- Sub-module can_register_cell: one WIDTH-bit register with mode, wr, rd_clr, hw_set, optional parity. Instantiated NUM_REGS times in a generate loop.
- Read mux and rvalid pipeline stay in the top module.

Test Plan:
- Reset: REG_MODE all RW, RESET_VALUE reg2=0xA5; assert rst 2 cycles -> reg_out field2=0xA5, others 0, rvalid=0; read addr2 -> rdata=0xA5 one cycle later.
- RW write/read: write 0x3C to reg1, read same cycle -> rdata = old value (0x00); next read -> 0x3C.
- W1C: reg3 W1C, hw_set bits 0 and 7 -> value 0x81, irq=1; write 0x01 with hw_set bit0 same cycle -> stays 0x81; write 0x81 -> 0x00, irq=0 next cycle.
- RC: reg4 RC, hw_set 0x10 -> read returns 0x10 and value 0x00 after; read with simultaneous hw_set 0x02 -> returns old value, value=0x02 afterwards.
- Out of range and RO: NUM_REGS=6, read addr 7 -> rdata=0, rvalid=1; write addr 7 -> no reg_out change; RO reg5 hw_val=0x5A -> read 0x5A, write 0xFF ignored.
- Parity (CAN_REG_PARITY_EN): parity_inject on write 0x01 to reg1, read reg1 -> parity_err=1 next cycle; held until rst; without the macro the same sequence reads 0x01 and no error.
